// File: rtl/vcpu32_rf_pkg.sv
// Shared types and limits for the parametrised VCPU-32 register file.
// Contents:
//   WORD_LENGTH  default register width (left untouched if already defined)
//   rf_state_t   clear-sweep state (RF_INIT while zeroing, RF_READY afterwards)
//   RF_MAX_RD    largest supported number of read ports
//   RF_MAX_WR    largest supported number of write ports
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package vcpu32_rf_pkg;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_MAX_RD = 4;
  localparam int RF_MAX_WR = 2;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file.
// It selects between zero, a forwarded same-cycle write, and the stored word.
// Ports:
//   ready    array initialised; when low the port reads zero
//   addr     read address
//   wr_en    per-write-port enables, already qualified (READY state, not dropped)
//   wr_addr  packed write addresses, port p at [p*AW +: AW]
//   wr_data  packed write data, port p at [p*WIDTH +: WIDTH]
//   stored   array word currently held at addr
//   data     read result
module register_file_read_port
  import vcpu32_rf_pkg::*;
#(
  parameter int AW       = 4,
  parameter int WIDTH    = 32,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    ready,
  input  logic [AW-1:0]           addr,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0]        stored,
  output logic [WIDTH-1:0]        data
);

  logic [WIDTH-1:0] mux_s;

  // Read mux: zero while not ready or for r0, otherwise bypass or stored word.
  always_comb begin
    mux_s = stored;
    if (!ready) begin
      mux_s = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      mux_s = '0;
    end else if (BYPASS != 0) begin
      // Walk from the highest port down so port 0 is applied last and wins.
      for (int p = NUM_WR - 1; p >= 0; p--) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
          mux_s = wr_data[p*WIDTH +: WIDTH];
        end else begin
          mux_s = mux_s;
        end
      end
    end else begin
      mux_s = stored;
    end
  end

  assign data = mux_s;

endmodule

// File: rtl/register_file_nr_nw.sv
// Parametrised N-read / N-write register file for the VCPU-32 pipeline.
// The array has no reset of its own: after rst or a clear request a sweep
// writes zero to one entry per cycle, and 'ready' rises once every entry
// has been cleared. This keeps the storage mappable onto FPGA RAM.
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   clear        request a full clear sweep
//   ready        array initialised; reads and writes honoured
//   readAddr     packed read addresses, port k at [k*AW +: AW]
//   readData     packed read data, port k at [k*WIDTH +: WIDTH]
//   writeEnable  per-port write enable
//   writeAddr    packed write addresses
//   writeData    packed write data
//   wrConflict   registered: both write ports hit one address last cycle
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module register_file_nr_nw
  import vcpu32_rf_pkg::*;
#(
  parameter  int SIZE     = 16,
  parameter  int WIDTH    = `WORD_LENGTH,
  parameter  int NUM_RD   = 3,
  parameter  int NUM_WR   = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  output logic                    ready,
  input  logic [NUM_RD*AW-1:0]    readAddr,
  output logic [NUM_RD*WIDTH-1:0] readData,
  input  logic [NUM_WR-1:0]       writeEnable,
  input  logic [NUM_WR*AW-1:0]    writeAddr,
  input  logic [NUM_WR*WIDTH-1:0] writeData,
  output logic                    wrConflict
);

  if ((NUM_RD < 1) || (NUM_RD > RF_MAX_RD)) begin : g_bad_num_rd
    $error("register_file_nr_nw: NUM_RD out of range");
  end
  if ((NUM_WR < 1) || (NUM_WR > RF_MAX_WR)) begin : g_bad_num_wr
    $error("register_file_nr_nw: NUM_WR out of range");
  end

  rf_state_t         state_r;
  logic [AW-1:0]     clr_ptr_r;
  logic              ready_r;
  logic              wr_conflict_r;
  logic [WIDTH-1:0]  mem_r [SIZE];
  logic [NUM_WR-1:0] wr_en_s;
  logic              conflict_s;

  assign ready      = ready_r;
  assign wrConflict = wr_conflict_r;

  // Qualified write enables: only in READY, and r0 writes dropped when hardwired.
  always_comb begin
    wr_en_s = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (state_r != RF_READY) begin
        wr_en_s[p] = 1'b0;
      end else if ((ZERO_REG != 0) && (writeAddr[p*AW +: AW] == '0)) begin
        wr_en_s[p] = 1'b0;
      end else begin
        wr_en_s[p] = writeEnable[p];
      end
    end
  end

  // Conflict uses the raw enables, so a clash on r0 is still reported.
  if (NUM_WR >= 2) begin : g_conflict
    assign conflict_s = writeEnable[0] & writeEnable[1] &
                        (writeAddr[0 +: AW] == writeAddr[AW +: AW]);
  end else begin : g_no_conflict
    assign conflict_s = 1'b0;
  end

  // Sweep FSM: clear pointer, ready flag and registered conflict pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RF_INIT;
      clr_ptr_r     <= '0;
      ready_r       <= 1'b0;
      wr_conflict_r <= 1'b0;
    end else begin
      case (state_r)
        RF_INIT: begin
          wr_conflict_r <= 1'b0;
          if (clear) begin
            clr_ptr_r <= '0;
          end else if (clr_ptr_r == AW'(SIZE - 1)) begin
            clr_ptr_r <= '0;
            state_r   <= RF_READY;
            ready_r   <= 1'b1;
          end else begin
            clr_ptr_r <= clr_ptr_r + AW'(1);
          end
        end
        RF_READY: begin
          wr_conflict_r <= conflict_s;
          if (clear) begin
            state_r   <= RF_INIT;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
          end else begin
            clr_ptr_r <= '0;
          end
        end
        default: begin
          state_r       <= RF_INIT;
          clr_ptr_r     <= '0;
          ready_r       <= 1'b0;
          wr_conflict_r <= 1'b0;
        end
      endcase
    end
  end

  // Array update: sweep zero in INIT, otherwise port writes with port 0 last so it wins.
  always_ff @(posedge clk) begin
    if (state_r == RF_INIT) begin
      mem_r[clr_ptr_r] <= '0;
    end else begin
      for (int p = NUM_WR - 1; p >= 0; p--) begin
        if (wr_en_s[p]) begin
          mem_r[writeAddr[p*AW +: AW]] <= writeData[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    register_file_read_port #(
      .AW       (AW),
      .WIDTH    (WIDTH),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .ready   (ready_r),
      .addr    (readAddr[k*AW +: AW]),
      .wr_en   (wr_en_s),
      .wr_addr (writeAddr),
      .wr_data (writeData),
      .stored  (mem_r[readAddr[k*AW +: AW]]),
      .data    (readData[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_register_file_nr_nw.sv
// Self-checking bench for register_file_nr_nw (SIZE=16, WIDTH=32, 3R/2W,
// bypass and hardwired r0 enabled). Expected read data is queued when the
// stimulus is applied and popped when the DUT output is sampled.
module tb_register_file_nr_nw;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        ready;
  logic [11:0] readAddr;
  logic [95:0] readData;
  logic [1:0]  writeEnable;
  logic [7:0]  writeAddr;
  logic [63:0] writeData;
  logic        wrConflict;

  logic [31:0] exp_q[$];
  int          pass_cnt;
  int          chk_cnt;

  register_file_nr_nw #(
    .SIZE     (16),
    .WIDTH    (32),
    .NUM_RD   (3),
    .NUM_WR   (2),
    .BYPASS   (1),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .ready       (ready),
    .readAddr    (readAddr),
    .readData    (readData),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .wrConflict  (wrConflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    int cycles;
    logic [31:0] exp;
    logic [31:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    readAddr    = {4'd3, 4'd2, 4'd1};
    writeEnable = 2'b11;
    writeAddr   = {4'd2, 4'd1};
    writeData   = {32'hBBBB0002, 32'hAAAA0001};
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    #1;
    chk_cnt++;
    if (ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", ready);
    else pass_cnt++;
    chk_cnt++;
    if (wrConflict !== 1'b0) $display("FAIL reset_conflict_low: got %b expected 0", wrConflict);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL init_read_zero port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
    cycles = 0;
    while ((ready !== 1'b1) && (cycles < 40)) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    writeEnable = 2'b00;
    chk_cnt++;
    if (cycles !== 16) $display("FAIL reset_sweep_len: got %0d cycles expected 16", cycles);
    else pass_cnt++;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      readAddr = {4'(a), 4'(a), 4'(a)};
      for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
      #1;
      for (int k = 0; k < 3; k++) begin
        exp = exp_q.pop_front();
        got = readData[k*32 +: 32];
        chk_cnt++;
        if (got !== exp) $display("FAIL swept_zero r%0d port%0d: got %h expected %h", a, k, got, exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    readAddr    = {4'd0, 4'd0, 4'd5};
    writeEnable = 2'b01;
    writeAddr   = {4'd0, 4'd5};
    writeData   = {32'h0, 32'hDEADBEEF};
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front();
    got = readData[31:0];
    chk_cnt++;
    if (got !== exp) $display("FAIL bypass_r5: got %h expected %h", got, exp);
    else pass_cnt++;
    @(negedge clk);
    writeEnable = 2'b00;
    writeData   = 64'h0;
    readAddr    = {4'd5, 4'd5, 4'd5};
    for (int k = 0; k < 3; k++) exp_q.push_back(32'hDEADBEEF);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL stored_r5 port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
    // Port 1 alone writes r6, seen through read port 2 in the same cycle.
    @(negedge clk);
    readAddr    = {4'd6, 4'd5, 4'd5};
    writeEnable = 2'b10;
    writeAddr   = {4'd6, 4'd0};
    writeData   = {32'hCAFEF00D, 32'h0};
    exp_q.push_back(32'hCAFEF00D);
    #1;
    exp = exp_q.pop_front();
    got = readData[95:64];
    chk_cnt++;
    if (got !== exp) $display("FAIL bypass_port1_r6: got %h expected %h", got, exp);
    else pass_cnt++;
    @(negedge clk);
    writeEnable = 2'b00;
    exp_q.push_back(32'hCAFEF00D);
    #1;
    exp = exp_q.pop_front();
    got = readData[95:64];
    chk_cnt++;
    if (got !== exp) $display("FAIL stored_r6: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    readAddr    = {4'd0, 4'd7, 4'd0};
    writeEnable = 2'b11;
    writeAddr   = {4'd7, 4'd7};
    writeData   = {32'h22222222, 32'h11111111};
    exp_q.push_back(32'h11111111);
    #1;
    exp = exp_q.pop_front();
    got = readData[63:32];
    chk_cnt++;
    if (got !== exp) $display("FAIL conflict_bypass_r7: got %h expected %h", got, exp);
    else pass_cnt++;
    chk_cnt++;
    if (wrConflict !== 1'b0) $display("FAIL conflict_same_cycle: got %b expected 0", wrConflict);
    else pass_cnt++;
    @(negedge clk);
    writeEnable = 2'b00;
    exp_q.push_back(32'h11111111);
    #1;
    chk_cnt++;
    if (wrConflict !== 1'b1) $display("FAIL conflict_pulse: got %b expected 1", wrConflict);
    else pass_cnt++;
    exp = exp_q.pop_front();
    got = readData[63:32];
    chk_cnt++;
    if (got !== exp) $display("FAIL conflict_stored_r7: got %h expected %h", got, exp);
    else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (wrConflict !== 1'b0) $display("FAIL conflict_pulse_end: got %b expected 0", wrConflict);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    readAddr    = {4'd0, 4'd0, 4'd0};
    writeEnable = 2'b01;
    writeAddr   = {4'd0, 4'd0};
    writeData   = {32'h0, 32'h12345678};
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL r0_write_cycle port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
    @(negedge clk);
    writeEnable = 2'b00;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL r0_after_write port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
    chk_cnt++;
    if (wrConflict !== 1'b0) $display("FAIL r0_no_conflict: got %b expected 0", wrConflict);
    else pass_cnt++;
    // Both ports on r0: data dropped, conflict still flagged.
    @(negedge clk);
    writeEnable = 2'b11;
    writeData   = {32'h55555555, 32'h66666666};
    @(negedge clk);
    writeEnable = 2'b00;
    exp_q.push_back(32'h0);
    #1;
    chk_cnt++;
    if (wrConflict !== 1'b1) $display("FAIL r0_conflict_flag: got %b expected 1", wrConflict);
    else pass_cnt++;
    exp = exp_q.pop_front();
    got = readData[31:0];
    chk_cnt++;
    if (got !== exp) $display("FAIL r0_conflict_data: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int cycles;
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    writeEnable = 2'b01;
    writeAddr   = {4'd0, 4'd3};
    writeData   = {32'h0, 32'hA5A5A5A5};
    @(negedge clk);
    clear       = 1'b1;
    writeAddr   = {4'd0, 4'd9};
    writeData   = {32'h0, 32'h99999999};
    readAddr    = {4'd0, 4'd9, 4'd3};
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'h99999999);
    #1;
    chk_cnt++;
    if (ready !== 1'b1) $display("FAIL clear_ready_before: got %b expected 1", ready);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL clear_cycle_read port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
    @(negedge clk);
    clear       = 1'b0;
    writeEnable = 2'b11;
    writeAddr   = {4'd3, 4'd3};
    writeData   = {32'hEEEEEEEE, 32'hFFFFFFFF};
    exp_q.push_back(32'h0);
    #1;
    chk_cnt++;
    if (ready !== 1'b0) $display("FAIL clear_ready_drop: got %b expected 0", ready);
    else pass_cnt++;
    exp = exp_q.pop_front();
    got = readData[31:0];
    chk_cnt++;
    if (got !== exp) $display("FAIL clear_init_read: got %h expected %h", got, exp);
    else pass_cnt++;
    cycles = 0;
    while ((ready !== 1'b1) && (cycles < 40)) begin
      @(posedge clk);
      #1;
      cycles++;
      chk_cnt++;
      if (wrConflict !== 1'b0) $display("FAIL clear_conflict_held cycle%0d: got %b expected 0", cycles, wrConflict);
      else pass_cnt++;
    end
    writeEnable = 2'b00;
    chk_cnt++;
    if (cycles !== 16) $display("FAIL clear_sweep_len: got %0d cycles expected 16", cycles);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      got = readData[k*32 +: 32];
      chk_cnt++;
      if (got !== exp) $display("FAIL cleared_read port%0d: got %h expected %h", k, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cycles;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk_cnt++;
    if (ready !== 1'b0) $display("FAIL mid_sweep_ready: got %b expected 0", ready);
    else pass_cnt++;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while ((ready !== 1'b1) && (cycles < 40)) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk_cnt++;
    if (cycles !== 16) $display("FAIL restart_sweep_len: got %0d cycles expected 16", cycles);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    chk_cnt     = 0;
    rst         = 1'b1;
    clear       = 1'b0;
    readAddr    = 12'h0;
    writeEnable = 2'b00;
    writeAddr   = 8'h0;
    writeData   = 64'h0;
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_clear();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
